// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one req/ack data-bus transaction per operation with timeout.
// Optional LSU_MISALIGNED_TRAP_EN: misaligned accesses skip the bus and report lsu_misaligned.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lsu_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    output logic        lsu_stall,
    output logic        lsu_done,
    output logic [31:0] lsu_rdata,
    output logic        lsu_bus_err,
    output logic        lsu_misaligned,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

`ifdef LSU_MISALIGNED_TRAP_EN
    localparam bit TrapEn = 1'b1;
`else
    localparam bit TrapEn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      state_q;
    logic [31:0] cnt_q;
    logic [29:0] addr_q;
    logic [1:0]  off_q;
    logic [2:0]  funct3_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        mis_q;

    logic        is_byte, is_half, mis_c, start, trap, busy, done, timeout;
    logic [1:0]  off_c;
    logic [3:0]  wstrb_c;
    logic [31:0] wdata_c, shifted, ext_rdata;

    // Without the trap, the lane offset is rounded down to the access size.
    always_comb begin
        is_byte = (funct3[1:0] == 2'b00);
        is_half = (funct3[1:0] == 2'b01);
        mis_c   = (is_half & alu_result[0]) | (!is_byte & !is_half & (|alu_result[1:0]));
        off_c   = 2'b00;
        wstrb_c = 4'b1111;
        wdata_c = store_data;
        if (is_byte) begin
            off_c   = alu_result[1:0];
            wstrb_c = 4'b0001 << off_c;
            wdata_c = {4{store_data[7:0]}};
        end else if (is_half) begin
            off_c   = {alu_result[1], 1'b0};
            wstrb_c = 4'b0011 << off_c;
            wdata_c = {2{store_data[15:0]}};
        end
    end

    always_comb begin
        shifted = dmem_rdata >> {off_q, 3'b000};
        case (funct3_q[1:0])
            2'b00:   ext_rdata = {{24{~funct3_q[2] & shifted[7]}}, shifted[7:0]};
            2'b01:   ext_rdata = {{16{~funct3_q[2] & shifted[15]}}, shifted[15:0]};
            default: ext_rdata = shifted;
        endcase
    end

    assign start   = lsu_valid & (mem_read | mem_write);
    assign trap    = TrapEn & mis_c;
    assign busy    = (state_q == StBusy);
    assign done    = (state_q == StDone);
    assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            addr_q   <= '0;
            off_q    <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        addr_q   <= alu_result[31:2];
                        off_q    <= off_c;
                        funct3_q <= funct3;
                        we_q     <= mem_write;
                        wdata_q  <= wdata_c;
                        wstrb_q  <= mem_write ? wstrb_c : 4'b0000;
                        rdata_q  <= '0;
                        err_q    <= 1'b0;
                        mis_q    <= trap;
                        cnt_q    <= '0;
                        state_q  <= trap ? StDone : StBusy;
                    end
                end
                StBusy: begin
                    // An ack on the timeout cycle still completes cleanly.
                    if (dmem_ack) begin
                        rdata_q <= we_q ? 32'h0 : ext_rdata;
                        state_q <= StDone;
                    end else if (timeout) begin
                        err_q   <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                StDone: begin
                    cnt_q   <= '0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign lsu_stall      = ((state_q == StIdle) & start) | busy;
    assign lsu_done       = done;
    assign lsu_rdata      = done ? rdata_q : 32'h0;
    assign lsu_bus_err    = done & err_q;
    assign lsu_misaligned = done & mis_q;
    assign dmem_req       = busy;
    assign dmem_we        = busy & we_q;
    assign dmem_addr      = busy ? {addr_q, 2'b00} : 32'h0;
    assign dmem_wdata     = busy ? wdata_q : 32'h0;
    assign dmem_wstrb     = busy ? wstrb_q : 4'b0000;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage block directly downstream of the execute ALU.
- Takes the ALU result as the effective address, together with rs2 store data and funct3.
- Runs one request/acknowledge transaction on the data-memory bus and returns aligned, sign- or zero-extended load data to writeback.
- Stalls the pipeline while a transaction is outstanding. A cycle counter bounds the wait and reports a bus error on timeout.

Parameters:
- TIMEOUT_CYCLES, 16: number of BUSY cycles without dmem_ack before a bus error is raised. 0 disables the timeout.

Ports:
- clk  input  1  core clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- lsu_valid  input  1  execute stage presents a memory operation this cycle
- mem_read  input  1  operation is a load
- mem_write  input  1  operation is a store
- funct3  input  3  RISC-V width/sign code
- alu_result  input  32  effective address from the ALU
- store_data  input  32  rs2 value
- lsu_stall  output  1  holds upstream stages
- lsu_done  output  1  one-cycle completion pulse
- lsu_rdata  output  32  extended load result; valid while lsu_done=1
- lsu_bus_err  output  1  timeout flag; valid while lsu_done=1
- lsu_misaligned  output  1  misaligned flag; valid while lsu_done=1
- dmem_req  output  1  bus request
- dmem_we  output  1  1 = write
- dmem_addr  output  32  word address, bits [1:0] = 00
- dmem_wdata  output  32  lane-replicated write data
- dmem_wstrb  output  4  byte enables; 0000 for loads
- dmem_ack  input  1  completes the transaction
- dmem_rdata  input  32  read word; valid with dmem_ack

Behaviour:
- Reset: state IDLE, timeout counter 0. All outputs 0.
- Reset mid-transaction: dmem_req is 0 in the cycle after reset is sampled. A late dmem_ack is ignored.
- States: IDLE, BUSY, DONE.
- IDLE:
  - start = lsu_valid & (mem_read | mem_write).
  - On start, capture address, store_data, funct3 and we = mem_write. mem_write has priority if both are high.
  - Go to BUSY, or to DONE on a trapped misalignment.
  - lsu_stall = start (combinational).
  - dmem_ack in IDLE is ignored.
- BUSY:
  - dmem_req = 1. dmem_addr, dmem_we, dmem_wdata and dmem_wstrb come from registers and are held stable until dmem_ack.
  - lsu_stall = 1.
  - On dmem_ack: latch extended rdata, go to DONE.
  - Otherwise the counter increments. When the counter equals TIMEOUT_CYCLES-1 with no ack: drop the request, set bus_err, go to DONE.
  - If the ack arrives on the timeout cycle, the ack wins and no error is raised.
- DONE:
  - lsu_done = 1 for exactly one cycle, lsu_stall = 0.
  - Counter cleared, return to IDLE.
  - Back-to-back operations: a new start is accepted in the first IDLE cycle. Minimum issue interval is 3 cycles.
- Latency: start to lsu_done is 2 cycles with a same-cycle ack (ack in the first BUSY cycle), plus 1 cycle per wait cycle.
- Lane offset: off = addr[1:0].
- SB (000): wstrb = 0001 << off, wdata = {4{byte}}.
- SH (001): wstrb = 0011 << off, wdata = {2{half}}.
- SW (010): wstrb = 1111.
- Loads:
  - LB (000) and LBU (100): byte at dmem_rdata[8*off+:8], sign- or zero-extended.
  - LH (001) and LHU (101): half at dmem_rdata[8*off+:16], sign- or zero-extended.
  - LW (010): full word.
- Other funct3 codes are treated as word access.
- Misaligned access: a half with addr[0]=1, or a word with addr[1:0]≠00.

Optional Feature:
- Macro: LSU_MISALIGNED_TRAP_EN.
- Defined:
  - A misaligned access issues no bus request and goes IDLE→DONE.
  - In the DONE cycle, lsu_misaligned=1 and lsu_rdata=0.
  - No write ever reaches memory.
- Undefined:
  - Low address bits are ignored for the access size (half uses addr[1]; word uses 00) and the access proceeds normally.
  - lsu_misaligned is tied 0.

Test Plan:
- LB, addr 0x1003, dmem_rdata 0x80FFFFFF with ack in the first BUSY cycle → lsu_rdata 0xFFFFFF80, lsu_done 2 cycles after start, bus_err 0.
- LHU, addr 0x2002, rdata 0xBEEF1234 → lsu_rdata 0x0000BEEF. LH on the same inputs → 0xFFFFBEEF.
- SB, addr 0x0001, store_data 0x000000A5 → dmem_wstrb 0010, dmem_wdata 0xA5A5A5A5, dmem_addr 0x0; fields held stable across 3 wait cycles.
- LW with no ack, TIMEOUT_CYCLES=16 → dmem_req high for 16 cycles then low; lsu_done with lsu_bus_err=1. A second run with ack on the 16th cycle → no error.
- SW to 0x0006: with the macro defined, dmem_req is never asserted and lsu_misaligned=1. Without the macro, dmem_addr=0x4 and wstrb=1111.
- Reset asserted in the 2nd BUSY cycle → dmem_req=0 and all outputs 0 on the next edge. A subsequent ack produces no lsu_done.
